// File: rtl/req_join_hs.sv
// rtl/req_join_hs.sv - N-way 4-phase request join with enable mask, stall timeout and join counter
module req_join_hs #(
    parameter int REQ_N   = 3,
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_N-1:0] reqs,
    input  logic [REQ_N-1:0] mask,
    output logic [REQ_N-1:0] acks,
    output logic             fin,
    input  logic             fin_ack,
    output logic             timeout,
    output logic [CNT_W-1:0] join_count
);

    typedef enum logic [1:0] {S_COLLECT, S_FIRE, S_ACK} state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [REQ_N-1:0]   captured_q, captured_d;
    logic [REQ_N-1:0]   mask_q, mask_d;
    logic [REQ_N-1:0]   acks_q, acks_d;
    logic               fin_q, fin_d;
    logic               timeout_q, timeout_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]   join_count_q, join_count_d;
    logic [REQ_N-1:0]   cap_next;
    logic               done_next;

    always_comb begin
        state_d      = state_q;
        captured_d   = captured_q;
        mask_d       = mask_q;
        acks_d       = acks_q;
        fin_d        = fin_q;
        timeout_d    = timeout_q;
        to_cnt_d     = to_cnt_q;
        join_count_d = join_count_q;
        cap_next     = captured_q | (reqs & mask);
        done_next    = (&(cap_next | ~mask)) && (|mask);

        case (state_q)
            S_COLLECT: begin
                captured_d = cap_next;
                if (done_next) begin
                    mask_d    = mask;
                    fin_d     = 1'b1;
                    timeout_d = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = S_FIRE;
                end else if ((|captured_q) && (TIMEOUT != 0)) begin
                    // Counter saturates at the limit; the flag then holds until the join fires.
                    if (to_cnt_q < TO_LIM)
                        to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_d >= TO_LIM)
                        timeout_d = 1'b1;
                end
            end
            S_FIRE: begin
                if (fin_ack) begin
                    fin_d   = 1'b0;
                    acks_d  = mask_q;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (((reqs & mask_q) == '0) && !fin_ack) begin
                    acks_d       = '0;
                    captured_d   = '0;
                    join_count_d = join_count_q + 1'b1;
                    state_d      = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_COLLECT;
            captured_q   <= '0;
            mask_q       <= '0;
            acks_q       <= '0;
            fin_q        <= 1'b0;
            timeout_q    <= 1'b0;
            to_cnt_q     <= '0;
            join_count_q <= '0;
        end else begin
            state_q      <= state_d;
            captured_q   <= captured_d;
            mask_q       <= mask_d;
            acks_q       <= acks_d;
            fin_q        <= fin_d;
            timeout_q    <= timeout_d;
            to_cnt_q     <= to_cnt_d;
            join_count_q <= join_count_d;
        end
    end

    assign acks       = acks_q;
    assign fin        = fin_q;
    assign timeout    = timeout_q;
    assign join_count = join_count_q;

endmodule

// File: tb/tb_req_join_hs.sv
// tb/tb_req_join_hs.sv - directed bench for req_join_hs with a per-cycle reference model
module tb_req_join_hs;

    localparam int N = 3;
    localparam int TO = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  reqs = '0;
    logic [N-1:0]  mask = '0;
    logic          fin_ack = 1'b0;
    logic [N-1:0]  acks;
    logic          fin;
    logic          timeout;
    logic [CW-1:0] join_count;

    int total = 0;
    int passed = 0;
    bit run_cmp = 0;

    req_join_hs #(.REQ_N(N), .TIMEOUT(TO), .TO_W(8), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .reqs(reqs), .mask(mask), .acks(acks),
        .fin(fin), .fin_ack(fin_ack), .timeout(timeout), .join_count(join_count)
    );

    always #5 clk = ~clk;

    // Reference: phase 0 = waiting for arrivals, 1 = downstream request out, 2 = acking producers
    int       m_phase = 0;
    bit       m_arrived [N];
    bit [N-1:0] m_part = '0;
    bit [N-1:0] m_acks = '0;
    bit       m_fin = 0;
    bit       m_to = 0;
    int       m_wait = 0;
    int       m_joins = 0;

    always @(posedge clk or posedge rst) begin : model
        bit any_old, all_in, any_en, rel;
        if (rst) begin
            m_phase <= 0; m_part <= '0; m_acks <= '0; m_fin <= 0;
            m_to <= 0; m_wait <= 0; m_joins <= 0;
            for (int i = 0; i < N; i++) m_arrived[i] <= 0;
        end else if (m_phase == 0) begin
            any_old = 0; all_in = 1; any_en = 0;
            for (int i = 0; i < N; i++) begin
                if (m_arrived[i]) any_old = 1;
                if (mask[i]) begin
                    any_en = 1;
                    if (!(m_arrived[i] || reqs[i])) all_in = 0;
                end
                if (mask[i] && reqs[i]) m_arrived[i] <= 1;
            end
            if (all_in && any_en) begin
                m_phase <= 1; m_fin <= 1; m_part <= mask; m_to <= 0; m_wait <= 0;
            end else if (any_old) begin
                m_wait <= m_wait + 1;
                if (m_wait + 1 >= TO) m_to <= 1;
            end
        end else if (m_phase == 1) begin
            if (fin_ack) begin
                m_phase <= 2; m_fin <= 0; m_acks <= m_part;
            end
        end else begin
            rel = 1;
            for (int i = 0; i < N; i++) if (m_part[i] && reqs[i]) rel = 0;
            if (rel && !fin_ack) begin
                m_phase <= 0; m_acks <= '0; m_joins <= (m_joins + 1) % (1 << CW);
                for (int i = 0; i < N; i++) m_arrived[i] <= 0;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("model_acks", int'(acks), int'(m_acks));
            chk("model_fin", int'(fin), int'(m_fin));
            chk("model_timeout", int'(timeout), int'(m_to));
            chk("model_join_count", int'(join_count), m_joins);
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] m, input logic fa);
        reqs = r; mask = m; fin_ack = fa;
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_fin", int'(fin), 0);
        chk("reset_acks", int'(acks), 0);
        chk("reset_count", int'(join_count), 0);
        chk("reset_timeout", int'(timeout), 0);
        @(posedge clk); #1 rst = 1'b0;
        run_cmp = 1;

        // T1: staggered arrivals
        cyc(3'b001, 3'b111, 0);
        cyc(3'b011, 3'b111, 0);
        chk("t1_fin_early", int'(fin), 0);
        cyc(3'b111, 3'b111, 0);
        chk("t1_fin", int'(fin), 1);
        cyc(3'b111, 3'b111, 1);
        chk("t1_acks", int'(acks), 7);
        chk("t1_fin_drop", int'(fin), 0);
        cyc(3'b000, 3'b111, 0);
        chk("t1_acks_clr", int'(acks), 0);
        chk("t1_count", int'(join_count), 1);

        // T2: channel 1 masked off
        cyc(3'b101, 3'b101, 0);
        chk("t2_fin", int'(fin), 1);
        cyc(3'b101, 3'b101, 1);
        chk("t2_acks", int'(acks), 5);
        cyc(3'b000, 3'b101, 0);
        chk("t2_count", int'(join_count), 2);

        // T3: stall timeout
        cyc(3'b001, 3'b111, 0);
        cyc(3'b001, 3'b111, 0);
        cyc(3'b001, 3'b111, 0);
        cyc(3'b001, 3'b111, 0);
        chk("t3_timeout_early", int'(timeout), 0);
        cyc(3'b001, 3'b111, 0);
        chk("t3_timeout", int'(timeout), 1);
        cyc(3'b001, 3'b111, 0);
        chk("t3_timeout_hold", int'(timeout), 1);
        cyc(3'b111, 3'b111, 0);
        chk("t3_fin", int'(fin), 1);
        chk("t3_timeout_clr", int'(timeout), 0);

        // T4: reqs fall while fin_ack still high
        cyc(3'b111, 3'b111, 1);
        cyc(3'b000, 3'b111, 1);
        chk("t4_acks_hold", int'(acks), 7);
        cyc(3'b000, 3'b111, 0);
        chk("t4_acks_clr", int'(acks), 0);
        chk("t4_count", int'(join_count), 3);

        // T6: counter wraps
        cyc(3'b111, 3'b111, 0);
        cyc(3'b111, 3'b111, 1);
        cyc(3'b000, 3'b111, 0);
        chk("t6_wrap", int'(join_count), 0);
        cyc(3'b111, 3'b111, 0);
        cyc(3'b111, 3'b111, 1);
        cyc(3'b000, 3'b111, 0);
        chk("t6_after_wrap", int'(join_count), 1);

        // T5: async reset while fin high
        cyc(3'b111, 3'b111, 0);
        chk("t5_fin_pre", int'(fin), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_fin", int'(fin), 0);
        chk("t5_acks", int'(acks), 0);
        chk("t5_count", int'(join_count), 0);
        @(negedge clk); rst = 1'b0;

        // mask==0 never fires
        cyc(3'b111, 3'b000, 0);
        cyc(3'b111, 3'b000, 0);
        cyc(3'b111, 3'b000, 1);
        chk("mask0_fin", int'(fin), 0);
        chk("mask0_timeout", int'(timeout), 0);
        repeat (6) cyc(3'b000, 3'b000, 0);

        run_cmp = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
